// File: rtl/xtal_osc_32k_ctrl.sv
// xtal_osc_32k_ctrl
//   Start-up and supervision controller for a 32.768 kHz crystal oscillator.
//   Enables the oscillator with boost, counts xtal edges through boost and
//   settle phases, then flags clk_good.  A missing first edge or a later
//   edge gap raises a sticky fault that is cleared only by dropping en.
//
// Ports
//   clk        system clock (>= 8x xtal frequency)
//   rst_n      asynchronous active-low reset
//   en         software run request
//   xtal_dout  oscillator digital output, asynchronous to clk
//   osc_ena    oscillator enable pin
//   osc_boost  oscillator boost pin
//   clk_good   xtal clock verified stable
//   fault      sticky fault (startup timeout or clock loss)
//   state      FSM state, for debug
module xtal_osc_32k_ctrl #(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [23:0] STARTUP_CYC  = 24'd2000000,
    parameter logic [15:0] BOOST_EDGES  = 16'd1024,
    parameter logic [15:0] SETTLE_EDGES = 16'd256,
    parameter logic [23:0] GAP_CYC      = 24'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       xtal_dout,
    output logic       osc_ena,
    output logic       osc_boost,
    output logic       clk_good,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_START  = 3'd1,
        S_BOOST  = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    // A zero edge target behaves like a target of one.
    localparam logic [15:0] BOOST_EFF  = (BOOST_EDGES  == 16'd0) ? 16'd1 : BOOST_EDGES;
    localparam logic [15:0] SETTLE_EFF = (SETTLE_EDGES == 16'd0) ? 16'd1 : SETTLE_EDGES;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    // One cycle counter serves both the START timeout and the edge-gap
    // watchdog: it clears on START entry and on every rise.
    logic [23:0]            cyc_q, cyc_d;
    logic [15:0]            edge_q, edge_d;
    logic                   osc_ena_q, osc_ena_d;
    logic                   osc_boost_q, osc_boost_d;
    logic                   clk_good_q, clk_good_d;
    logic                   fault_q, fault_d;

    logic                   rise;
    logic [23:0]            cyc_inc;
    logic [15:0]            edge_inc;
    logic                   gap_exp;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], xtal_dout};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    assign rise     = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign cyc_inc  = (cyc_q == 24'hFF_FFFF) ? cyc_q : cyc_q + 24'd1;
    assign edge_inc = (edge_q == 16'hFFFF) ? edge_q : edge_q + 16'd1;
    assign gap_exp  = (cyc_inc >= GAP_CYC);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_inc;
        edge_d  = edge_q;
        if (!en) begin
            state_d = S_OFF;
            cyc_d   = '0;
            edge_d  = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d = S_START;
                    cyc_d   = '0;
                    edge_d  = '0;
                end
                S_START: begin
                    if (rise) begin
                        cyc_d = '0;
                        // With a boost target of one, the first edge completes boost.
                        if (BOOST_EFF == 16'd1) begin
                            state_d = S_SETTLE;
                            edge_d  = '0;
                        end else begin
                            state_d = S_BOOST;
                            edge_d  = 16'd1;
                        end
                    end else if (cyc_inc >= STARTUP_CYC) begin
                        state_d = S_FAULT;
                    end
                end
                S_BOOST: begin
                    // A rise always wins over a simultaneous gap expiry.
                    if (rise) begin
                        cyc_d  = '0;
                        edge_d = edge_inc;
                        if (edge_inc >= BOOST_EFF) begin
                            state_d = S_SETTLE;
                            edge_d  = '0;
                        end
                    end else if (gap_exp) begin
                        state_d = S_FAULT;
                    end
                end
                S_SETTLE: begin
                    if (rise) begin
                        cyc_d  = '0;
                        edge_d = edge_inc;
                        if (edge_inc >= SETTLE_EFF) state_d = S_RUN;
                    end else if (gap_exp) begin
                        state_d = S_FAULT;
                    end
                end
                S_RUN: begin
                    if (rise)         cyc_d   = '0;
                    else if (gap_exp) state_d = S_FAULT;
                end
                S_FAULT: begin
                    cyc_d = cyc_q;
                end
                default: begin
                    state_d = S_OFF;
                    cyc_d   = '0;
                    edge_d  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered pins line
    // up with state_q (clk_good rises on the edge that enters RUN).
    always_comb begin
        osc_ena_d   = (state_d == S_START) || (state_d == S_BOOST) ||
                      (state_d == S_SETTLE) || (state_d == S_RUN);
        osc_boost_d = (state_d == S_START) || (state_d == S_BOOST);
        clk_good_d  = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            sync_q      <= '0;
            hist_q      <= 1'b0;
            cyc_q       <= '0;
            edge_q      <= '0;
            osc_ena_q   <= 1'b0;
            osc_boost_q <= 1'b0;
            clk_good_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            hist_q      <= hist_d;
            cyc_q       <= cyc_d;
            edge_q      <= edge_d;
            osc_ena_q   <= osc_ena_d;
            osc_boost_q <= osc_boost_d;
            clk_good_q  <= clk_good_d;
            fault_q     <= fault_d;
        end
    end

    assign osc_ena   = osc_ena_q;
    assign osc_boost = osc_boost_q;
    assign clk_good  = clk_good_q;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_xtal_osc_32k_ctrl.sv
// Directed bench for xtal_osc_32k_ctrl with short start-up parameters.
module tb_xtal_osc_32k_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       xtal_dout;
    logic       osc_ena, osc_boost, clk_good, fault;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    xtal_osc_32k_ctrl #(
        .SYNC_STAGES (2),
        .STARTUP_CYC (24'd100),
        .BOOST_EDGES (16'd4),
        .SETTLE_EDGES(16'd2),
        .GAP_CYC     (24'd40)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .xtal_dout(xtal_dout),
        .osc_ena  (osc_ena),
        .osc_boost(osc_boost),
        .clk_good (clk_good),
        .fault    (fault),
        .state    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks state and the packed {ena, boost, good, fault} outputs.
    task automatic chk_o(input string tag, input logic [2:0] st, input logic [3:0] outs);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".outs"}, 32'({osc_ena, osc_boost, clk_good, fault}), 32'(outs));
    endtask

    // One xtal period starting high; call at a negedge, returns at a negedge.
    task automatic xcyc(input int hi, input int lo);
        xtal_dout = 1'b1;
        repeat (hi) @(negedge clk);
        xtal_dout = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; xtal_dout = 1'b0;
        #7;
        chk_o("reset", 3'd0, 4'b0000);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk_o("idle_off", 3'd0, 4'b0000);

        // Nominal start-up
        en = 1'b1;
        @(negedge clk);
        chk_o("start", 3'd1, 4'b1100);
        xcyc(10, 10);
        chk_o("boost_r1", 3'd2, 4'b1100);
        xcyc(10, 10); xcyc(10, 10);
        chk_o("boost_r3", 3'd2, 4'b1100);
        xcyc(10, 10);
        chk_o("settle_r4", 3'd3, 4'b1000);
        xcyc(10, 10);
        chk_o("settle_r5", 3'd3, 4'b1000);
        xtal_dout = 1'b1;
        repeat (2) @(negedge clk);
        chk_o("pre_run", 3'd3, 4'b1000);
        @(negedge clk);
        chk_o("run_r6", 3'd4, 4'b1010);

        // Clock loss in RUN: xtal stays high, no further rises
        repeat (39) @(negedge clk);
        chk_o("loss_39", 3'd4, 4'b1010);
        @(negedge clk);
        chk_o("loss_40", 3'd5, 4'b0001);
        repeat (5) @(negedge clk);
        chk_o("fault_sticky", 3'd5, 4'b0001);
        xtal_dout = 1'b0;
        en = 1'b0;
        @(negedge clk);
        chk_o("en_off", 3'd0, 4'b0000);

        // Dead crystal
        en = 1'b1;
        repeat (100) @(negedge clk);
        chk_o("dead_99", 3'd1, 4'b1100);
        @(negedge clk);
        chk_o("dead_100", 3'd5, 4'b0001);
        en = 1'b0;
        @(negedge clk);
        chk_o("dead_off", 3'd0, 4'b0000);
        en = 1'b1;
        @(negedge clk);
        chk_o("dead_restart", 3'd1, 4'b1100);

        // en dropped mid-BOOST, then fresh edge count
        xcyc(10, 10); xcyc(10, 10);
        chk_o("drop_boost_r2", 3'd2, 4'b1100);
        en = 1'b0;
        @(negedge clk);
        chk_o("drop_off", 3'd0, 4'b0000);
        en = 1'b1;
        @(negedge clk);
        chk_o("drop_restart", 3'd1, 4'b1100);
        xcyc(10, 10); xcyc(10, 10); xcyc(10, 10);
        chk_o("fresh_r3", 3'd2, 4'b1100);
        xcyc(10, 10);
        chk_o("fresh_r4", 3'd3, 4'b1000);
        xcyc(10, 10); xcyc(10, 10);
        chk_o("fresh_run", 3'd4, 4'b1010);

        // Async reset between clk edges in RUN
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_o("async_rst", 3'd0, 4'b0000);
        @(negedge clk);
        chk_o("rst_hold", 3'd0, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk_o("rst_restart", 3'd1, 4'b1100);

        // Boundary gaps in RUN: 39 and 40 survive, 41 faults
        repeat (6) xcyc(10, 10);
        chk_o("gap_run", 3'd4, 4'b1010);
        xcyc(5, 34);
        xcyc(5, 35);
        chk_o("gap_39", 3'd4, 4'b1010);
        xcyc(5, 36);
        chk_o("gap_40", 3'd4, 4'b1010);
        xtal_dout = 1'b1;
        @(negedge clk);
        chk_o("gap_41_pre", 3'd4, 4'b1010);
        @(negedge clk);
        chk_o("gap_41", 3'd5, 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/xtal_osc_32k_ctrl.md
XTAL_OSC_32K_CTRL -- requirements
Module: xtal_osc_32k_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth for xtal_dout (legal range 2..4).
REQ-002 SHALL have parameter STARTUP_CYC, default 24'd2000000: clk cycles allowed from START entry to the first xtal rising edge.
REQ-003 SHALL have parameter BOOST_EDGES, default 16'd1024: xtal rising edges counted with boost on.
REQ-004 SHALL have parameter SETTLE_EDGES, default 16'd256: xtal rising edges counted after boost is released.
REQ-005 SHALL have parameter GAP_CYC, default 24'd1000: maximum clk cycles between consecutive xtal rising edges before a loss fault.
REQ-006 SHALL have the following ports, clock and reset first:
  clk  input  1  system clock, at least 8x the 32.768 kHz xtal frequency.
  rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
  en  input  1  software request to run the oscillator.
  xtal_dout  input  1  oscillator digital output, asynchronous to clk.
  osc_ena  output  1  drives the oscillator ena pin.
  osc_boost  output  1  drives the oscillator boost pin.
  clk_good  output  1  xtal clock verified stable.
  fault  output  1  sticky fault flag (startup timeout or clock loss).
  state  output  3  FSM state, for debug.

Function
REQ-007 SHALL pass xtal_dout through a SYNC_STAGES flop synchronizer plus one history flop; rise = sync_out AND NOT history, a single-clk pulse.
REQ-008 SHALL implement the states OFF=0, START=1, BOOST=2, SETTLE=3, RUN=4 and FAULT=5; the encodings 6 and 7 SHALL go to OFF on the next clk.
REQ-009 SHALL register all outputs, decoded from the state: osc_ena=1 in START, BOOST, SETTLE and RUN; osc_boost=1 in START and BOOST; clk_good=1 only in RUN; fault=1 only in FAULT.
REQ-010 SHALL move OFF->START when en=1; the cycle counter and edge counter SHALL clear on entry.
REQ-011 SHALL handle START as follows: on a rise, go to BOOST with the edge counter set to 1; if STARTUP_CYC cycles elapse with no rise, go to FAULT.
REQ-012 SHALL handle BOOST as follows: each rise increments the edge counter; the rise that makes the count equal BOOST_EDGES goes to SETTLE and clears the edge counter.
REQ-013 SHALL handle SETTLE as follows: each rise increments the edge counter; the rise that makes the count equal SETTLE_EDGES goes to RUN.
REQ-014 SHALL run a gap counter in BOOST, SETTLE and RUN: it clears on each rise and otherwise increments, saturating; when it reaches GAP_CYC the FSM goes to FAULT.
REQ-015 SHALL treat a rise and a gap-counter expiry in the same cycle as a rise, with no fault.
REQ-016 SHALL go to OFF on the next clk, from any state including FAULT, when en=0; en=0 SHALL take priority over every other transition.
REQ-017 SHALL keep FAULT sticky while en=1; leaving FAULT SHALL require an en 1->0->1 sequence.
REQ-018 SHALL treat a BOOST_EDGES or SETTLE_EDGES value of 0 as 1.
REQ-019 SHALL size counters at 16 bits for edges and 24 bits for cycles, with no wrap; the cycle counters SHALL saturate.
REQ-020 SHALL produce clk_good rising exactly one clk after the qualifying rise pulse.

Reset
REQ-021 SHALL asynchronously force, on rst_n=0, state=OFF, all counters 0, all synchronizer flops 0 and all outputs 0.
REQ-022 SHALL resume, after rst_n is released, only at a clk edge, starting from OFF; a reset mid-RUN SHALL deassert clk_good and osc_ena immediately.

Verification
Bench setup: clk 10 ns; STARTUP_CYC=100, BOOST_EDGES=4, SETTLE_EDGES=2, GAP_CYC=40; xtal period 20 clks unless stated.
REQ-023 SHALL cover nominal startup: en=1 with xtal toggling -> osc_boost=1 until the 4th rise; clk_good=1 one clk after the 6th rise; fault=0 throughout.
REQ-024 SHALL cover a dead crystal: en=1 with xtal_dout held 0 -> FAULT after 100 clks, with fault=1 and osc_ena=0; then en 0->1 -> START, fault=0.
REQ-025 SHALL cover clock loss in RUN: stop xtal in RUN -> FAULT exactly 40 clks after the last rise; clk_good falls at the same edge.
REQ-026 SHALL cover en dropped mid-BOOST after the 2nd rise -> OFF on the next clk with all outputs 0; a subsequent en=1 restarts with a fresh edge count of 4.
REQ-027 SHALL cover async reset asserted in RUN, between clk edges -> all outputs 0 immediately; after release with en=1 -> START on the next clk.
REQ-028 SHALL cover a boundary gap: rise at gap count 39 -> no fault; a rise exactly coinciding with expiry -> no fault (per REQ-015); a gap of 41 -> fault.
